// File: rtl/div_result_stage.sv
// Registered result stage behind a combinational 4-bit non-restoring divider.
// It corrects the remainder, handles divide-by-zero, buffers results and counts deliveries.
module div_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  input  logic [4:0]       in_r,
  input  logic [3:0]       in_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_q,
  output logic [3:0]       out_r,
  output logic             out_dz,
  output logic             out_err,
  output logic [CNT_W-1:0] res_cnt,
  output logic [CNT_W-1:0] dz_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  // Entry layout: {err, dz, r[3:0], q[3:0]}
  logic [9:0]       w_slots [DEPTH];
  logic [9:0]       w_entry;
  logic [9:0]       w_head;
  logic [9:0]       w_shown;
  logic [9:0]       r_last;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_res_cnt;
  logic [CNT_W-1:0] r_dz_cnt;

  logic       w_push;
  logic       w_pop;
  logic [4:0] w_sum5;
  logic [4:0] w_corr5;
  logic       w_range_err;
  logic [3:0] w_q;
  logic [3:0] w_r;
  logic       w_dz;
  logic       w_err;

  assign in_ready  = (r_occ != FULL_OCC);
  assign out_valid = (r_occ != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // A negative raw remainder is pulled back into range by adding the divisor once.
  assign w_sum5      = in_r + {1'b0, in_y};
  assign w_corr5     = in_r[4] ? w_sum5 : in_r;
  assign w_range_err = w_corr5[4] | (w_corr5[3:0] >= in_y);

  always_comb begin
    w_q   = in_q;
    w_r   = w_corr5[3:0];
    w_dz  = 1'b0;
    w_err = w_range_err;
    if (in_y == 4'd0) begin
      w_q   = 4'hF;
      w_r   = in_x;
      w_dz  = 1'b1;
      w_err = 1'b0;
    end
  end

  assign w_entry = {w_err, w_dz, w_r, w_q};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [9:0] r_data;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_data <= w_entry;
        end
      end
      assign w_slots[gi] = r_data;
    end
  endgenerate

  assign w_head = w_slots[r_rd_ptr];
  // When empty, the outputs keep showing the most recently delivered result.
  assign w_shown = out_valid ? w_head : r_last;

  assign out_q     = w_shown[3:0];
  assign out_r     = w_shown[7:4];
  assign out_dz    = w_shown[8];
  assign out_err   = w_shown[9];
  assign res_cnt   = r_res_cnt;
  assign dz_cnt    = r_dz_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
        r_last   <= w_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_cnt <= '0;
      r_dz_cnt  <= '0;
    end else if (w_pop) begin
      if (r_res_cnt != '1) begin
        r_res_cnt <= r_res_cnt + 1'b1;
      end
      if (w_head[8] && (r_dz_cnt != '1)) begin
        r_dz_cnt <= r_dz_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_result_stage.sv
// Directed bench for div_result_stage: correction, divide-by-zero, backpressure, reset, saturation.
module tb_div_result_stage;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic [4:0] in_r;
  logic [3:0] in_q;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_q;
  logic [3:0] out_r;
  logic       out_dz;
  logic       out_err;
  logic [7:0] res_cnt;
  logic [7:0] dz_cnt;

  int total = 0;
  int bad   = 0;

  div_result_stage #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_r(in_r), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .out_err(out_err),
    .res_cnt(res_cnt), .dz_cnt(dz_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic [4:0] r, input logic [3:0] q);
    in_valid = 1'b1;
    in_x = x; in_y = y; in_r = r; in_q = q;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_r = '0; in_q = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_dz", out_dz, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_res_cnt", res_cnt, 0);
    chk("rst_dz_cnt", dz_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // 12 / 3: exact quotient 4, remainder 0
    out_ready = 1'b1;
    drive(4'd12, 4'd3, 5'b00000, 4'd4);
    step(); in_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_q", out_q, 4);
    chk("t1_r", out_r, 0);
    chk("t1_dz", out_dz, 0);
    chk("t1_err", out_err, 0);
    step();
    chk("t1_empty", out_valid, 0);
    chk("t1_res_cnt", res_cnt, 1);
    chk("t1_hold_q", out_q, 4);

    // 5 / 10: raw remainder -5 corrected to 5
    drive(4'd5, 4'd10, 5'b11011, 4'd0);
    step(); in_valid = 1'b0;
    chk("t2_q", out_q, 0);
    chk("t2_r", out_r, 5);
    chk("t2_err", out_err, 0);
    step();
    chk("t2_res_cnt", res_cnt, 2);

    // 13 / 0: divide-by-zero ignores in_r / in_q
    drive(4'd13, 4'd0, 5'b10101, 4'd7);
    step(); in_valid = 1'b0;
    chk("t3_q", out_q, 4'hF);
    chk("t3_r", out_r, 13);
    chk("t3_dz", out_dz, 1);
    chk("t3_err", out_err, 0);
    step();
    chk("t3_dz_cnt", dz_cnt, 1);
    chk("t3_res_cnt", res_cnt, 3);
    chk("t3_hold_dz", out_dz, 1);

    // remainder 12 with divisor 9 flags a range error but is still delivered
    drive(4'd12, 4'd9, 5'b01100, 4'd1);
    step(); in_valid = 1'b0;
    chk("t4_valid", out_valid, 1);
    chk("t4_err", out_err, 1);
    chk("t4_r", out_r, 12);
    chk("t4_q", out_q, 1);
    step();
    chk("t4_res_cnt", res_cnt, 4);

    // Backpressure: A, B fill the FIFO, C is held upstream
    out_ready = 1'b0;
    drive(4'd7, 4'd2, 5'b00001, 4'd3);
    chk("bp_ready_a", in_ready, 1);
    step();
    drive(4'd10, 4'd4, 5'b11110, 4'd2);
    chk("bp_ready_b", in_ready, 1);
    step();
    drive(4'd15, 4'd0, 5'b00000, 4'd0);
    chk("bp_full", in_ready, 0);
    step();
    chk("bp_still_full", in_ready, 0);
    chk("bp_head_a_q", out_q, 3);
    chk("bp_head_a_r", out_r, 1);
    out_ready = 1'b1;
    step();
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_head_b_q", out_q, 2);
    chk("bp_head_b_r", out_r, 2);
    chk("bp_res_cnt_a", res_cnt, 5);
    step(); in_valid = 1'b0;
    chk("bp_head_c_q", out_q, 4'hF);
    chk("bp_head_c_r", out_r, 15);
    chk("bp_head_c_dz", out_dz, 1);
    chk("bp_occ_one", out_valid, 1);
    step();
    chk("bp_drained", out_valid, 0);
    chk("bp_res_cnt", res_cnt, 7);
    chk("bp_dz_cnt", dz_cnt, 2);

    // Reset with two buffered entries
    out_ready = 1'b0;
    drive(4'd7, 4'd2, 5'b00001, 4'd3);
    step();
    drive(4'd10, 4'd4, 5'b11110, 4'd2);
    step(); in_valid = 1'b0;
    chk("mr_full", in_ready, 0);
    chk("mr_valid_before", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_res_cnt", res_cnt, 0);
    chk("mr_dz_cnt", dz_cnt, 0);
    chk("mr_out_q", out_q, 0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_ready", in_ready, 1);
    chk("mr_still_empty", out_valid, 0);

    // Counter saturation: 260 back-to-back divide-by-zero results
    out_ready = 1'b1;
    drive(4'd1, 4'd0, 5'b00000, 4'd0);
    for (int i = 0; i < 260; i++) step();
    in_valid = 1'b0;
    step();
    step();
    chk("sat_res_cnt", res_cnt, 8'hFF);
    chk("sat_dz_cnt", dz_cnt, 8'hFF);
    chk("sat_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_result_stage.md
Name: div_result_stage

Overview:
- Registered output stage directly downstream of the combinational 4-bit non-restoring divider (inputs X/Y, raw outputs R[4:0]/Q[3:0]).
- Accepts operand/raw-result sets under a valid/ready handshake and applies the final non-restoring remainder correction.
- Handles divide-by-zero and buffers results in a small FIFO for a valid/ready consumer.
- Keeps saturating statistics counters.

Parameters:
- DEPTH, 2, result FIFO entries; legal values 2..8.
- CNT_W, 8, width of statistics counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream presents a set (X, Y, R, Q).
- in_ready  output  1  stage can accept a set this cycle.
- in_x  input  4  dividend fed to the divider.
- in_y  input  4  divisor fed to the divider.
- in_r  input  5  raw two's-complement remainder from the divider.
- in_q  input  4  quotient from the divider.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer accepts the head this cycle.
- out_q  output  4  final quotient.
- out_r  output  4  corrected non-negative remainder.
- out_dz  output  1  result came from divide-by-zero.
- out_err  output  1  corrected remainder failed the range check.
- res_cnt  output  CNT_W  results delivered, saturating.
- dz_cnt  output  CNT_W  divide-by-zero results delivered, saturating.

Behaviour:
- Reset (async, immediate): FIFO empty, out_valid=0, out_q=0, out_r=0, out_dz=0, out_err=0, res_cnt=0, dz_cnt=0.
  - in_ready=1 once reset deasserts.
  - A reset mid-operation discards all buffered entries; nothing partial is ever emitted.
- Accept condition: in_valid & in_ready on a rising edge. in_ready = !full, computed combinationally from the occupancy count only (no dependence on out_ready).
- Correction is combinational on the inputs; its result is written into the FIFO at accept:
  - Y==0: q=4'hF, r=in_x, dz=1, err=0. in_r and in_q are ignored.
  - Otherwise, if in_r[4]==1: r = (in_r + {1'b0,in_y})[3:0]; else r = in_r[3:0].
  - Otherwise, q = in_q, dz=0.
  - Otherwise, err=1 when the corrected 5-bit value is negative or >= in_y; the entry is still stored.
- Latency: accept into an empty FIFO gives out_valid=1 on the next cycle. There is no same-cycle bypass.
- Output fields are driven from the FIFO head and are stable while out_valid & !out_ready.
- Pop condition: out_valid & out_ready. On a pop:
  - res_cnt increments by 1.
  - dz_cnt increments by 1 if the head had dz=1.
  - Both counters saturate at all-ones.
- Simultaneous push and pop:
  - When full: in_ready=0, so no push occurs; the pop frees a slot that becomes visible next cycle.
  - When not full: push and pop both happen and occupancy is unchanged.
- FIFO is in-order. Read/write pointers wrap modulo DEPTH; occupancy counter width is clog2(DEPTH+1).
- Empty: out_valid=0, and out_q/out_r/out_dz/out_err hold their last values (0 after reset).

Test Plan:
- Reset, then push X=12, Y=3, R=5'b00000, Q=4'b0100 with out_ready=1 -> one cycle later out_valid=1, out_q=4, out_r=0, dz=0, err=0; res_cnt=1 after the pop.
- Push X=5, Y=10, R=5'b11011 (-5), Q=0 -> out_r=5, out_q=0, err=0.
- Push X=13, Y=0 with any R/Q -> out_q=4'hF, out_r=13, out_dz=1; dz_cnt=1 after the pop.
- Push R=5'b01100 with Y=9 -> out_err=1 (12 >= 9), result still delivered.
- With out_ready=0, push three sets at DEPTH=2 -> in_ready drops after two accepts and the third is held upstream. Then assert out_ready -> order 1, 2, 3 is preserved, no loss or duplication.
- Assert rst while the FIFO holds two entries -> out_valid=0 immediately and both counters read 0.
